// File: rtl/obstacle_scheduler.sv
// Runner-game obstacle pool, per-frame walk and game FSM (IDLE/RUN/PAUSED/OVER).
// Define OBSTACLE_RANDOM_LANE_EN for LFSR lane choice; default is round-robin lanes.
module obstacle_scheduler #(
    parameter int NSLOTS         = 4,
    parameter int SPAWN_INTERVAL = 40,
    parameter int SPAWN_X        = 616,
    parameter int LANE_BASE      = 75,
    parameter int LANE_STEP      = 100,
    parameter int BASE_SPEED     = 5,
    parameter int MAX_SPEED      = 12,
    parameter int LEVEL_STEP     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 collision,
    output logic [NSLOTS*10-1:0] obj_x,
    output logic [NSLOTS*9-1:0]  obj_y,
    output logic [NSLOTS-1:0]    obj_active,
    output logic [1:0]           state,
    output logic [3:0]           level,
    output logic [15:0]          score,
    output logic                 busy,
    output logic                 overrun,
    output logic [7:0]           drop_cnt
);

    localparam int SW = $clog2(NSLOTS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t            st, st_n;
    logic [9:0]        xs [NSLOTS];
    logic [8:0]        ys [NSLOTS];
    logic [NSLOTS-1:0] act, free_sel;
    logic [SW-1:0]     step;
    logic              busy_q, ovr_q;
    logic [3:0]        level_q;
    logic [15:0]       score_q, score_inc, spawn_cnt;
    logic [7:0]        drop_q;
    logic [5:0]        spd_raw, speed;
    logic [1:0]        lane_k;
    logic              restart, walk_go, spawn_due, free_any;

`ifdef OBSTACLE_RANDOM_LANE_EN
    logic [7:0] lfsr;
    assign lane_k = lfsr[1:0];
`else
    logic [1:0] lane_ptr;
    assign lane_k = lane_ptr;
`endif

    assign spd_raw   = 6'(BASE_SPEED) + {2'b00, level_q};
    assign speed     = (spd_raw > 6'(MAX_SPEED)) ? 6'(MAX_SPEED) : spd_raw;
    assign score_inc = score_q + 16'd1;
    assign restart   = start && (st == IDLE || st == OVER);
    assign walk_go   = (st == RUN) && !busy_q && !collision && !pause && frame_tick;
    assign spawn_due = (spawn_cnt == 16'(SPAWN_INTERVAL - 1));

    // Lowest-index free slot; sees slots freed earlier in the same walk.
    always_comb begin
        free_sel = '0;
        free_any = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (!act[i] && !free_any) begin
                free_sel[i] = 1'b1;
                free_any    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_n;
    end

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE:   if (start) st_n = RUN;
            RUN: begin
                if (!busy_q) begin
                    if (collision)  st_n = OVER;
                    else if (pause) st_n = PAUSED;
                end
            end
            PAUSED: if (!pause) st_n = RUN;
            OVER:   if (start) st_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOTS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
            act       <= '0;
            step      <= '0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            level_q   <= '0;
            score_q   <= '0;
            spawn_cnt <= '0;
            drop_q    <= '0;
`ifdef OBSTACLE_RANDOM_LANE_EN
            lfsr      <= 8'hA5;
`else
            lane_ptr  <= '0;
`endif
        end else begin
            if (restart) begin
                for (int i = 0; i < NSLOTS; i++) begin
                    xs[i] <= '0;
                    ys[i] <= '0;
                end
                act       <= '0;
                score_q   <= '0;
                level_q   <= '0;
                spawn_cnt <= '0;
                drop_q    <= '0;
                ovr_q     <= 1'b0;
            end
            if (busy_q && frame_tick) ovr_q <= 1'b1;
            if (walk_go) begin
                busy_q <= 1'b1;
                step   <= '0;
            end else if (busy_q) begin
                step <= step + SW'(1);
                if (step == SW'(NSLOTS)) begin
                    busy_q <= 1'b0;
                    if (spawn_due) begin
                        spawn_cnt <= '0;
`ifdef OBSTACLE_RANDOM_LANE_EN
                        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
                        if (free_any) begin
                            for (int i = 0; i < NSLOTS; i++) begin
                                if (free_sel[i]) begin
                                    xs[i]  <= 10'(SPAWN_X);
                                    ys[i]  <= 9'(LANE_BASE + int'(lane_k) * LANE_STEP);
                                    act[i] <= 1'b1;
                                end
                            end
`ifndef OBSTACLE_RANDOM_LANE_EN
                            lane_ptr <= lane_ptr + 2'd1;
`endif
                        end else if (drop_q != 8'hFF) begin
                            drop_q <= drop_q + 8'd1;
                        end
                    end else begin
                        spawn_cnt <= spawn_cnt + 16'd1;
                    end
                end else begin
                    for (int i = 0; i < NSLOTS; i++) begin
                        if (step == SW'(i) && act[i]) begin
                            if (xs[i] < 10'(speed)) begin
                                act[i] <= 1'b0;
                                if (score_q != 16'hFFFF) begin
                                    score_q <= score_inc;
                                    if (score_inc % 16'(LEVEL_STEP) == 16'd0 &&
                                        level_q != 4'hF)
                                        level_q <= level_q + 4'd1;
                                end
                            end else begin
                                xs[i] <= xs[i] - 10'(speed);
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        obj_x = '0;
        obj_y = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            obj_x[10*i +: 10] = xs[i];
            obj_y[9*i +: 9]   = ys[i];
        end
    end

    assign obj_active = act;
    assign state      = st;
    assign level      = level_q;
    assign score      = score_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized bench for obstacle_scheduler against a frame-level reference model.
// Positions/score/level are compared whenever no walk is pending.
module tb_obstacle_scheduler;

    localparam int NS  = 4;
    localparam int SI  = 4;
    localparam int BS  = 7;
    localparam int MS  = 12;
    localparam int SX  = 616;
    localparam int LB  = 75;
    localparam int LST = 100;
    localparam int LVS = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           frame_tick = 1'b0;
    logic           start = 1'b0;
    logic           pause = 1'b0;
    logic           collision = 1'b0;
    logic [NS*10-1:0] obj_x;
    logic [NS*9-1:0]  obj_y;
    logic [NS-1:0]    obj_active;
    logic [1:0]       state;
    logic [3:0]       level;
    logic [15:0]      score;
    logic             busy;
    logic             overrun;
    logic [7:0]       drop_cnt;

    obstacle_scheduler #(
        .NSLOTS(NS), .SPAWN_INTERVAL(SI), .SPAWN_X(SX), .LANE_BASE(LB),
        .LANE_STEP(LST), .BASE_SPEED(BS), .MAX_SPEED(MS), .LEVEL_STEP(LVS)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .pause(pause), .collision(collision), .obj_x(obj_x), .obj_y(obj_y),
        .obj_active(obj_active), .state(state), .level(level), .score(score),
        .busy(busy), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: whole walk is evaluated when the tick is accepted.
    int m_x[NS], m_y[NS], m_act[NS];
    int m_state = 0, m_level = 0, m_score = 0, m_drop = 0;
    int m_cnt = 0, m_lane = 0, m_left = 0, m_ovr = 0;

    task automatic m_clear();
        for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_act[i] = 0;
        end
        m_level = 0; m_score = 0; m_drop = 0; m_cnt = 0; m_ovr = 0;
    endtask

    task automatic m_walk();
        int sp, fr;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i] != 0) begin
                sp = (BS + m_level > MS) ? MS : BS + m_level;
                if (m_x[i] < sp) begin
                    m_act[i] = 0;
                    if (m_score < 65535) begin
                        m_score++;
                        if (m_score % LVS == 0 && m_level < 15) m_level++;
                    end
                end else begin
                    m_x[i] -= sp;
                end
            end
        end
        if (m_cnt == SI - 1) begin
            m_cnt = 0;
            fr = -1;
            for (int i = NS - 1; i >= 0; i--) if (m_act[i] == 0) fr = i;
            if (fr >= 0) begin
                m_x[fr] = SX; m_y[fr] = LB + m_lane * LST; m_act[fr] = 1;
                m_lane = (m_lane + 1) % 4;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        int wb;
        m_clear();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_clear();
                m_state = 0; m_lane = 0; m_left = 0;
            end else begin
                wb = (m_left > 0) ? 1 : 0;
                if (wb != 0 && frame_tick) m_ovr = 1;
                if (wb != 0) m_left--;
                case (m_state)
                    0, 3: if (start) begin m_clear(); m_state = 1; end
                    1: if (wb == 0) begin
                        if (collision) m_state = 3;
                        else if (pause) m_state = 2;
                        else if (frame_tick) begin m_walk(); m_left = NS + 1; end
                    end
                    2: if (!pause) m_state = 1;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("state", int'(state), m_state);
        chk("busy", int'(busy), (m_left > 0) ? 1 : 0);
        chk("overrun", int'(overrun), m_ovr);
        if (m_left == 0) begin
            chk("level", int'(level), m_level);
            chk("score", int'(score), m_score);
            chk("drop_cnt", int'(drop_cnt), m_drop);
            for (int i = 0; i < NS; i++) begin
                chk("obj_active", int'(obj_active[i]), m_act[i]);
                chk("obj_x", int'(obj_x[10*i +: 10]), m_x[i]);
                chk("obj_y", int'(obj_y[9*i +: 9]), m_y[i]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic wait_idle(output int bc);
        bc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) bc++;
            else break;
        end
        if (busy) chk("walk_timeout", 1, 0);
    endtask

    task automatic tick(output int bc);
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        wait_idle(bc);
    endtask

    initial begin
        int bc, f, lvl_exp;
        cyc(3);
        rst = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_active", int'(obj_active), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_busy", int'(busy), 0);
        pulse_start();
        chk("start_state", int'(state), 1);

        for (f = 1; f <= 93; f++) begin
            tick(bc);
            if (f <= 3) chk("busy_len", bc, NS + 1);
            if (f == 4) begin
                chk("f4_active", int'(obj_active), 1);
                chk("f4_x0", int'(obj_x[9:0]), 616);
                chk("f4_y0", int'(obj_y[8:0]), 75);
            end
            if (f == 16) begin
                chk("f16_active", int'(obj_active), 15);
                chk("f16_y1", int'(obj_y[17:9]), 175);
                chk("f16_y2", int'(obj_y[26:18]), 275);
                chk("f16_y3", int'(obj_y[35:27]), 375);
            end
            if (f == 20) begin
                chk("f20_drop", int'(drop_cnt), 1);
                chk("f20_active", int'(obj_active), 15);
            end
            if (f == 92) chk("f92_x0", int'(obj_x[9:0]), 0);
            if (f == 93) begin
                chk("f93_act0", int'(obj_active[0]), 0);
                chk("f93_score", int'(score), 1);
            end
            cyc($urandom_range(0, 2));
        end

        // Overrun: second tick two clocks into a walk.
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        cyc(1);
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        wait_idle(bc);
        chk("overrun_set", int'(overrun), 1);
        cyc(1);

        // Run until level saturates, checking level against score.
        for (f = 0; f < 5000 && !(m_level == 15 && m_score > 15 * LVS + 8); f++) begin
            tick(bc);
            lvl_exp = (int'(score) / LVS > 15) ? 15 : int'(score) / LVS;
            chk("level_vs_score", int'(level), lvl_exp);
            cyc($urandom_range(0, 3));
        end
        chk("level_sat", int'(level), 15);

        pause = 1'b1;
        cyc(2);
        for (int k = 0; k < 10; k++) begin
            tick(bc);
            chk("pause_busy", bc, 0);
            cyc(1);
        end
        chk("pause_state", int'(state), 2);
        pause = 1'b0;
        cyc(2);
        chk("resume_state", int'(state), 1);

        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        cyc(2);
        collision = 1'b1;
        wait_idle(bc);
        cyc(2);
        collision = 1'b0;
        chk("over_state", int'(state), 3);
        for (int k = 0; k < 3; k++) begin tick(bc); cyc(1); end
        pulse_start();
        chk("restart_state", int'(state), 1);
        chk("restart_active", int'(obj_active), 0);
        chk("restart_score", int'(score), 0);
        chk("restart_level", int'(level), 0);
        chk("restart_ovr", int'(overrun), 0);

        for (int k = 0; k < 6; k++) begin tick(bc); cyc($urandom_range(0, 2)); end
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        cyc(2);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("rstmid_state", int'(state), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_active", int'(obj_active), 0);
        chk("rstmid_x", int'(obj_x), 0);
        chk("rstmid_score", int'(score), 0);
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
